// File: rtl/mdriver_axil_bridge.sv
// Purpose : executes one mdriver exec/fin command as a single AXI4-Lite write or read.
// Latency : exec sampled at edge N -> fin high after edge N+3 with immediately-responding slave.
// Backpres: each AXI valid is held until its handshake; exec/fin is a four-phase handshake.
//
// Ports:
//   clk, nreset                 clock, synchronous active-low reset
//   si_address, si_data, we     command captured on the edge that samples exec=1 in IDLE
//   exec / fin                  four-phase request / completion
//   so_data, resp_err           last read data, last command response status
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite master port
module mdriver_axil_bridge #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   si_address,
  input  logic [C_AXI_DATA_WIDTH-1:0]   si_data,
  input  logic                          we,
  input  logic                          exec,
  output logic [C_AXI_DATA_WIDTH-1:0]   so_data,
  output logic                          fin,
  output logic                          resp_err,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                        state_q;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_AXI_DATA_WIDTH-1:0]   so_data_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          bready_q;
  logic                          arvalid_q;
  logic                          rready_q;
  logic                          fin_q;
  logic                          resp_err_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      so_data_q  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      fin_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exec) begin
            // Command fields are latched only here; later si_* changes are ignored.
            addr_q  <= si_address;
            wdata_q <= si_data;
            if (we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W retire independently; a channel already retired counts as done.
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_q   <= 1'b0;
            resp_err_q <= (m_axi_bresp != 2'b00);
            fin_q      <= 1'b1;
            state_q    <= DONE;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (m_axi_rvalid) begin
            rready_q   <= 1'b0;
            so_data_q  <= m_axi_rdata;
            resp_err_q <= (m_axi_rresp != 2'b00);
            fin_q      <= 1'b1;
            state_q    <= DONE;
          end
        end

        DONE: begin
          // Leaving only on exec=0 means a held exec can never start a second command;
          // if exec already dropped early, fin is high for exactly this one cycle.
          if (!exec) begin
            fin_q   <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign so_data       = so_data_q;
  assign fin           = fin_q;
  assign resp_err      = resp_err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_mdriver_axil_bridge.sv
// Bench for mdriver_axil_bridge: directed commands, AXI4-Lite slave model with
// configurable stalls, expected results queued at issue and checked on fin rise.
module tb_mdriver_axil_bridge;

  logic        clk;
  logic        nreset;
  logic [31:0] si_address;
  logic [31:0] si_data;
  logic        we;
  logic        exec;
  logic [31:0] so_data;
  logic        fin;
  logic        resp_err;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  mdriver_axil_bridge #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32)) dut (
    .clk(clk), .nreset(nreset),
    .si_address(si_address), .si_data(si_data), .we(we), .exec(exec),
    .so_data(so_data), .fin(fin), .resp_err(resp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] so;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration
  int       aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] mem [0:63];

  // slave / monitor bookkeeping
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, fin_rise_cnt = 0;
  logic saw_split = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
    end
  endtask

  // AXI4-Lite slave. Everything is evaluated at the falling edge for the next rising
  // edge. Address/data readies rise after *_delay cycles of valid. The response is
  // registered off the master's ready: valid rises one cycle after ready is seen,
  // plus *_delay further cycles.
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic wr_a_got, wr_d_got, rd_got, b_fire, r_fire;
    logic aw_hold, w_hold, ar_hold, bready_prev;
    logic [31:0] wr_addr, wr_data, rd_addr, hold_awaddr, hold_wdata, hold_araddr;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    wr_a_got = 0; wr_d_got = 0; rd_got = 0; b_fire = 0; r_fire = 0;
    aw_hold = 0; w_hold = 0; ar_hold = 0; bready_prev = 0;
    wr_addr = 0; wr_data = 0; rd_addr = 0; hold_awaddr = 0; hold_wdata = 0; hold_araddr = 0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        wr_a_got = 0; wr_d_got = 0; rd_got = 0; b_fire = 0; r_fire = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0; bready_prev = 0;
      end else begin
        // a valid not yet accepted must stay up with stable payload
        if (aw_hold) begin
          chk("awvalid_held", 32'(m_axi_awvalid), 1);
          chk("awaddr_stable", m_axi_awaddr, hold_awaddr);
        end
        if (w_hold) begin
          chk("wvalid_held", 32'(m_axi_wvalid), 1);
          chk("wdata_stable", m_axi_wdata, hold_wdata);
        end
        if (ar_hold) begin
          chk("arvalid_held", 32'(m_axi_arvalid), 1);
          chk("araddr_stable", m_axi_araddr, hold_araddr);
        end
        if (m_axi_bready && !bready_prev)
          chk("bready_after_aw_and_w", 32'(wr_a_got && wr_d_got), 1);
        bready_prev = m_axi_bready;

        m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
        if (m_axi_awvalid && !m_axi_awready) aw_wait++;
        aw_hold = m_axi_awvalid && !m_axi_awready;
        hold_awaddr = m_axi_awaddr;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_wait = 0; aw_cnt++; wr_a_got = 1; wr_addr = m_axi_awaddr;
          if (exp_aw_q.size() == 0) chk("aw_expected", 0, 1);
          else chk("awaddr", m_axi_awaddr, exp_aw_q.pop_front());
          chk("awprot", 32'(m_axi_awprot), 0);
        end

        m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
        if (m_axi_wvalid && !m_axi_wready) w_wait++;
        w_hold = m_axi_wvalid && !m_axi_wready;
        hold_wdata = m_axi_wdata;
        if (m_axi_wvalid && m_axi_wready) begin
          w_wait = 0; w_cnt++; wr_d_got = 1; wr_data = m_axi_wdata;
          if (exp_w_q.size() == 0) chk("w_expected", 0, 1);
          else chk("wdata", m_axi_wdata, exp_w_q.pop_front());
          chk("wstrb", 32'(m_axi_wstrb), 32'hF);
        end

        m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
        if (m_axi_arvalid && !m_axi_arready) ar_wait++;
        ar_hold = m_axi_arvalid && !m_axi_arready;
        hold_araddr = m_axi_araddr;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_wait = 0; ar_cnt++; rd_got = 1; rd_addr = m_axi_araddr;
          if (exp_ar_q.size() == 0) chk("ar_expected", 0, 1);
          else chk("araddr", m_axi_araddr, exp_ar_q.pop_front());
          chk("arprot", 32'(m_axi_arprot), 0);
        end

        if (b_fire) begin
          m_axi_bvalid = 0; b_fire = 0; wr_a_got = 0; wr_d_got = 0; b_wait = 0;
        end else if (wr_a_got && wr_d_got && m_axi_bready) begin
          b_wait++;
          if (b_wait >= b_delay + 2) begin
            m_axi_bvalid = 1; m_axi_bresp = bresp_cfg;
            mem[wr_addr[7:2]] = wr_data; b_fire = 1; b_cnt++;
          end
        end

        if (r_fire) begin
          m_axi_rvalid = 0; r_fire = 0; rd_got = 0; r_wait = 0;
        end else if (rd_got && m_axi_rready) begin
          r_wait++;
          if (r_wait >= r_delay + 2) begin
            m_axi_rvalid = 1; m_axi_rresp = rresp_cfg;
            m_axi_rdata = mem[rd_addr[7:2]]; r_fire = 1; r_cnt++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: each fin rise consumes one expected result.
  initial begin
    exp_t e;
    logic fin_prev;
    fin_prev = 0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        exp_q.delete();
        fin_prev = 0;
      end else begin
        if (fin && !fin_prev) begin
          fin_rise_cnt++;
          if (exp_q.size() == 0) chk("fin_expected", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("so_data", so_data, e.so);
            chk("resp_err", 32'(resp_err), 32'(e.err));
          end
        end
        fin_prev = fin;
        if (m_axi_awvalid && !m_axi_wvalid) saw_split = 1;
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_fin", 32'(fin), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_so_data", so_data, 0);
    chk("rst_valids_readies",
        32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);
  endtask

  // Full four-phase command; exec held two cycles past fin, then released.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_so, input logic exp_err, input int exp_lat);
    int cyc;
    if (w) begin
      exp_aw_q.push_back(a);
      exp_w_q.push_back(d);
    end else begin
      exp_ar_q.push_back(a);
    end
    exp_q.push_back('{so: exp_so, err: exp_err});
    @(posedge clk); #1;
    we = w; si_address = a; si_data = d; exec = 1;
    @(posedge clk); #1;
    si_address = 32'hFFFF_FFFF; si_data = 32'hFFFF_FFFF; we = ~w;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fin && cyc < 200);
    if (!fin) chk("fin_timeout", 0, 1);
    else if (exp_lat >= 0) chk("fin_latency", 32'(cyc), 32'(exp_lat + 1));
    repeat (2) begin
      @(negedge clk);
      chk("fin_held", 32'(fin), 1);
    end
    @(posedge clk); #1;
    exec = 0;
    @(posedge clk);
    @(negedge clk);
    chk("fin_drop", 32'(fin), 0);
  endtask

  initial begin
    int b_aw, b_w, b_ar, b_b, b_fin, cyc;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h24 >> 2] = 32'h1234_5678;
    mem[32'h30 >> 2] = 32'hAAAA_5555;
    nreset = 0; exec = 0; we = 0; si_address = 0; si_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    nreset = 1;

    // zero-wait write: fin three edges after exec sampled
    b_aw = aw_cnt; b_w = w_cnt; b_b = b_cnt;
    run_cmd(1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 3);
    chk("wr_aw_count", 32'(aw_cnt - b_aw), 1);
    chk("wr_w_count", 32'(w_cnt - b_w), 1);
    chk("wr_b_count", 32'(b_cnt - b_b), 1);

    // read with AR and R stalls
    ar_delay = 3; r_delay = 2;
    run_cmd(0, 32'h24, 32'h0, 32'h1234_5678, 0, -1);
    ar_delay = 0; r_delay = 0;

    // W accepted four cycles before AW
    aw_delay = 4; saw_split = 0; b_b = b_cnt; b_aw = aw_cnt;
    run_cmd(1, 32'h08, 32'hCAFE_F00D, 32'h1234_5678, 0, -1);
    aw_delay = 0;
    chk("split_w_first", 32'(saw_split), 1);
    chk("split_b_count", 32'(b_cnt - b_b), 1);
    chk("split_aw_count", 32'(aw_cnt - b_aw), 1);

    // error read, then OKAY write clears resp_err but keeps so_data
    rresp_cfg = 2'b10;
    run_cmd(0, 32'h30, 32'h0, 32'hAAAA_5555, 1, 3);
    rresp_cfg = 2'b00;
    run_cmd(1, 32'h34, 32'h5, 32'hAAAA_5555, 0, 3);

    // back-to-back write then read of the same address
    b_aw = aw_cnt; b_w = w_cnt; b_ar = ar_cnt; b_fin = fin_rise_cnt;
    run_cmd(1, 32'h04, 32'h1, 32'hAAAA_5555, 0, 3);
    run_cmd(0, 32'h04, 32'h0, 32'h1, 0, 3);
    chk("b2b_aw_count", 32'(aw_cnt - b_aw), 1);
    chk("b2b_w_count", 32'(w_cnt - b_w), 1);
    chk("b2b_ar_count", 32'(ar_cnt - b_ar), 1);
    chk("b2b_fin_pulses", 32'(fin_rise_cnt - b_fin), 2);

    // error write: resp_err set, so_data untouched
    bresp_cfg = 2'b11;
    run_cmd(1, 32'h40, 32'h7, 32'h1, 1, 3);
    bresp_cfg = 2'b00;

    // reset while waiting in RD_RESP
    r_delay = 10;
    exp_ar_q.push_back(32'h24);
    @(posedge clk); #1;
    we = 0; si_address = 32'h24; exec = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!m_axi_rready && cyc < 50);
    chk("rd_resp_reached", 32'(m_axi_rready), 1);
    @(posedge clk); #1;
    nreset = 0; exec = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    nreset = 1;
    r_delay = 0;
    run_cmd(0, 32'h24, 32'h0, 32'h1234_5678, 0, 3);

    // exec dropped before fin: command completes, fin high exactly one cycle
    b_ar = ar_cnt;
    exp_ar_q.push_back(32'h04);
    exp_q.push_back('{so: 32'h1, err: 1'b0});
    @(posedge clk); #1;
    we = 0; si_address = 32'h04; exec = 1;
    @(posedge clk); #1;
    exec = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fin && cyc < 50);
    chk("early_exec_fin_seen", 32'(fin), 1);
    @(negedge clk);
    chk("early_exec_fin_one_cycle", 32'(fin), 0);
    repeat (5) @(negedge clk);
    chk("early_exec_ar_count", 32'(ar_cnt - b_ar), 1);
    chk("exp_queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdriver_axil_bridge.md
Name: mdriver_axil_bridge

Overview:
- Slave-side responder for the mdriver exec/fin command interface.
- Accepts one command at a time from the master end (address, data, we, exec) and executes it as a single AXI4-Lite write or read on a master port.
- Returns read data on so_data and completes the four-phase exec/fin handshake.
- Sits between the test/driver side and any AXI4-Lite slave register block.

Parameters:
- C_AXI_DATA_WIDTH, 32, width of si_data, so_data, wdata and rdata.
- C_AXI_ADDR_WIDTH, 32, width of si_address, awaddr and araddr.

Ports:
- clk  input  1  clock, all logic on rising edge.
- nreset  input  1  reset; one clock; reset is synchronous and active-low.
- si_address  input  C_AXI_ADDR_WIDTH  command address.
- si_data  input  C_AXI_DATA_WIDTH  write data.
- we  input  1  1=write, 0=read.
- exec  input  1  command request (four-phase).
- so_data  output  C_AXI_DATA_WIDTH  last read data.
- fin  output  1  command complete (four-phase).
- resp_err  output  1  last completed command had a non-OKAY response.
- m_axi_awaddr/awprot[3]/awvalid  output, m_axi_awready  input.
- m_axi_wdata/wstrb[DATA/8]/wvalid  output, m_axi_wready  input.
- m_axi_bresp[2]/bvalid  input, m_axi_bready  output.
- m_axi_araddr/arprot[3]/arvalid  output, m_axi_arready  input.
- m_axi_rdata/rresp[2]/rvalid  input, m_axi_rready  output.

Behaviour:
- Reset (nreset=0 at a clk edge): state IDLE; fin, resp_err, awvalid, wvalid, bready, arvalid, rready = 0; so_data, awaddr, araddr, wdata = 0.
- Reset mid-transaction aborts immediately to IDLE with the above values. The attached AXI slave shares nreset.
- Constant outputs: awprot = arprot = 3'b000; wstrb all ones.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - Waits for exec=1. fin is 0.
  - On the edge sampling exec=1: registers si_address and si_data into awaddr/araddr/wdata.
  - If we=1: go to WR_REQ with awvalid=wvalid=1 from the next cycle.
  - If we=0: go to RD_REQ with arvalid=1.
  - si_* are not sampled after this edge.
- WR_REQ:
  - awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready. The two complete independently, in either order or the same cycle.
  - When both are done, go to WR_RESP (bready=1).
  - No valid is ever lowered before its handshake.
- WR_RESP:
  - On bvalid&bready: bready=0; resp_err <= (bresp != 2'b00); go to DONE with fin=1 next cycle.
  - so_data is unchanged by writes.
- RD_REQ: on arvalid&arready, arvalid=0, rready=1, go to RD_RESP.
- RD_RESP: on rvalid&rready: rready=0; so_data <= rdata; resp_err <= (rresp != 2'b00); go to DONE, fin=1.
- DONE:
  - fin held 1 while exec=1.
  - On the edge sampling exec=0: fin=0, go to IDLE.
  - exec remaining high never retriggers a command.
- Minimum latency, assuming all readies and valids respond immediately:
  - Write: exec sampled at edge N → fin=1 after edge N+3.
  - Read: same, fin=1 after edge N+3.
- resp_err and so_data persist until the next completed command or reset.
- Responses arriving in states not expecting them (e.g. bvalid in IDLE) are ignored; bready/rready stay 0.
- exec falling before fin (protocol violation): the command still completes. fin pulses for exactly one cycle and the FSM then returns to IDLE.

Test Plan:
- Write, zero-wait slave: we=1, addr=0x10, data=0xDEADBEEF, exec=1 → awaddr=0x10 and wdata=0xDEADBEEF with one-cycle valids; bresp=OKAY → fin=1 three cycles after exec sampled, resp_err=0; exec=0 → fin=0 next cycle.
- Read with stalls: we=0, addr=0x24; arready delayed 3 cycles, rvalid delayed 2 cycles with rdata=0x12345678 → arvalid stable until accepted; so_data=0x12345678 and fin=1 after rvalid&rready.
- Split write channels: wready 4 cycles before awready → wvalid drops first, awvalid persists; bready rises only after both handshakes; one B accepted.
- Error response: read with rresp=2'b10, data 0xAAAA5555 → so_data=0xAAAA5555, resp_err=1; following write with bresp=OKAY → resp_err=0, so_data still 0xAAAA5555.
- Back-to-back: execute_write(0x04,1) then execute_read(0x04) with slave echoing → exactly one AW, one W, one AR; fin has two clean pulses; so_data=1.
- Reset mid-read: nreset=0 while in RD_RESP → next cycle all valids/readies, fin, resp_err=0; after release, a new read completes normally.
